// File: rtl/mm_pkg.sv
// Shared definitions for the MM instruction dispatcher: instruction field map,
// buffer-select encodings, retire status codes and the dispatch FSM states.
package mm_pkg;

   localparam int MM_INST_W   = 128;
   localparam int IN_SEL_LSB  = 1;
   localparam int OUT_SEL_LSB = 7;
   localparam int RELU_BIT    = 12;
   localparam int ACC_BIT     = 13;
   localparam int BIAS_BIT    = 14;
   localparam int NNODE_LSB   = 110;
   localparam int NNODE_W     = MM_INST_W - NNODE_LSB;

   localparam logic [3:0] BUF_1A = 4'b0001;
   localparam logic [3:0] BUF_1B = 4'b0010;
   localparam logic [3:0] BUF_2A = 4'b0100;
   localparam logic [3:0] BUF_2B = 4'b1000;

   typedef enum logic [1:0] {
      STATUS_OK      = 2'd0,
      STATUS_SKIP    = 2'd1,
      STATUS_ILLEGAL = 2'd2
   } status_e;

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT,
      RET
   } state_e;

   // Output must be a 2x buffer, and reading the same 2x buffer that is being written is an alias.
   function automatic logic sel_illegal(input logic [3:0] in_sel, input logic [3:0] out_sel);
      logic out_ok;
      out_ok = (out_sel == BUF_2A) || (out_sel == BUF_2B);
      return !$onehot(in_sel) || !out_ok || ((in_sel & out_sel) != 4'b0000);
   endfunction

endpackage

// File: rtl/mm_inst_dispatch_if.sv
// Handshake bundle between the decoder, the dispatcher, the MM engine and the scheduler.
// The master modport is the dispatcher's view; slave is the surrounding environment.
interface mm_inst_dispatch_if #(
   parameter int MM_INST_BIT_WIDTH = 128,
   parameter int TAG_W             = 8
) ();

   logic                         inst_valid;
   logic                         inst_ready;
   logic [MM_INST_BIT_WIDTH-1:0] inst_data;
   logic [TAG_W-1:0]             inst_tag;
   logic [MM_INST_BIT_WIDTH-1:0] ctrl_instruction;
   logic                         ap_start;
   logic                         ap_done;
   logic                         ret_valid;
   logic                         ret_ready;
   logic [TAG_W-1:0]             ret_tag;
   logic [1:0]                   ret_status;

   modport master (
      input  inst_valid, inst_data, inst_tag, ap_done, ret_ready,
      output inst_ready, ctrl_instruction, ap_start, ret_valid, ret_tag, ret_status
   );

   modport slave (
      output inst_valid, inst_data, inst_tag, ap_done, ret_ready,
      input  inst_ready, ctrl_instruction, ap_start, ret_valid, ret_tag, ret_status
   );

endinterface

// File: rtl/mm_inst_fifo.sv
// Synchronous FIFO of {tag, instruction} entries with full/empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module mm_inst_fifo #(
   parameter int WIDTH = 136,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);

endmodule

// File: rtl/mm_inst_dispatch.sv
// Issue stage for the MM engine: queues instructions, validates buffer selects, starts the
// engine and retires each instruction with a status. MM_DISPATCH_PERF_EN adds a busy-cycle counter.
module mm_inst_dispatch
   import mm_pkg::*;
#(
   parameter int MM_INST_BIT_WIDTH = 128,
   parameter int FIFO_DEPTH        = 4,
   parameter int TAG_W             = 8
) (
   input  logic                kernal_clk,
   input  logic                kernal_rst,
   mm_inst_dispatch_if.master  bus,
   output logic                busy,
   output logic [31:0]         perf_busy_cycles
);

   localparam int ENTRY_W = TAG_W + MM_INST_BIT_WIDTH;

   state_e                       state;
   logic                         fifo_full;
   logic                         fifo_empty;
   logic                         push;
   logic                         pop;
   logic [ENTRY_W-1:0]           head;
   logic [MM_INST_BIT_WIDTH-1:0] head_inst;
   logic [TAG_W-1:0]             head_tag;

   assign {head_tag, head_inst} = head;

   assign pop            = (state == IDLE) && !fifo_empty;
   assign bus.inst_ready = !kernal_rst && (!fifo_full || pop);
   assign push           = bus.inst_valid && bus.inst_ready;
   assign busy           = (state != IDLE) || !fifo_empty;

   mm_inst_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (kernal_clk),
      .rst     (kernal_rst),
      .wr_en   (push),
      .wr_data ({bus.inst_tag, bus.inst_data}),
      .rd_en   (pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // ctrl_instruction is only reloaded on a pop; the engine decodes it combinationally.
   always_ff @(posedge kernal_clk) begin
      if (kernal_rst) begin
         state                <= IDLE;
         bus.ctrl_instruction <= '0;
         bus.ap_start         <= 1'b0;
         bus.ret_valid        <= 1'b0;
         bus.ret_tag          <= '0;
         bus.ret_status       <= STATUS_OK;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  bus.ctrl_instruction <= head_inst;
                  bus.ret_tag          <= head_tag;
                  if (sel_illegal(head_inst[IN_SEL_LSB +: 4], head_inst[OUT_SEL_LSB +: 4])) begin
                     bus.ret_status <= STATUS_ILLEGAL;
                     bus.ret_valid  <= 1'b1;
                     state          <= RET;
                  end else if (head_inst[NNODE_LSB +: NNODE_W] == '0) begin
                     bus.ret_status <= STATUS_SKIP;
                     bus.ret_valid  <= 1'b1;
                     state          <= RET;
                  end else begin
                     bus.ap_start <= 1'b1;
                     state        <= START;
                  end
               end
            end
            START: begin
               bus.ap_start <= 1'b0;
               state        <= WAIT;
            end
            WAIT: begin
               if (bus.ap_done) begin
                  bus.ret_status <= STATUS_OK;
                  bus.ret_valid  <= 1'b1;
                  state          <= RET;
               end
            end
            RET: begin
               if (bus.ret_ready) begin
                  bus.ret_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef MM_DISPATCH_PERF_EN
   // Saturating count of cycles spent starting or waiting on the engine.
   always_ff @(posedge kernal_clk) begin
      if (kernal_rst) begin
         perf_busy_cycles <= '0;
      end else if (((state == START) || (state == WAIT)) && (perf_busy_cycles != 32'hFFFF_FFFF)) begin
         perf_busy_cycles <= perf_busy_cycles + 32'd1;
      end
   end
`else
   assign perf_busy_cycles = '0;
`endif

endmodule

// File: tb/tb_mm_inst_dispatch.sv
// Directed testbench for mm_inst_dispatch with a retire scoreboard and a simple MM engine model.
module tb_mm_inst_dispatch;
   import mm_pkg::*;

   localparam int W     = 128;
   localparam int DEPTH = 4;
   localparam int TAG_W = 8;

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [1:0]       status;
      logic [W-1:0]     inst;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        busy;
   logic [31:0] perf;
   logic        eng_done  = 1'b0;
   logic        spur_done = 1'b0;
   logic        in_exec   = 1'b0;

   int checks      = 0;
   int errors      = 0;
   int starts      = 0;
   int retired     = 0;
   int exec_cycles = 0;
   int done_delay  = 20;
   int done_timer  = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   mm_inst_dispatch_if #(.MM_INST_BIT_WIDTH(W), .TAG_W(TAG_W)) bus ();

   assign bus.ap_done = eng_done | spur_done;

   mm_inst_dispatch #(
      .MM_INST_BIT_WIDTH (W),
      .FIFO_DEPTH        (DEPTH),
      .TAG_W             (TAG_W)
   ) dut (
      .kernal_clk       (clk),
      .kernal_rst       (rst),
      .bus              (bus),
      .busy             (busy),
      .perf_busy_cycles (perf)
   );

   task automatic check_output(input string name, input logic [W-1:0] observed, input logic [W-1:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
      end
   endtask

   function automatic logic [1:0] model_status(input logic [W-1:0] inst);
      logic [3:0]  i_s;
      logic [3:0]  o_s;
      logic [17:0] n;
      i_s = inst[4:1];
      o_s = inst[10:7];
      n   = inst[127:110];
      if (!(i_s inside {4'b0001, 4'b0010, 4'b0100, 4'b1000})) return 2'd2;
      if (!(o_s inside {4'b0100, 4'b1000})) return 2'd2;
      if (i_s == o_s) return 2'd2;
      if (n == 18'd0) return 2'd1;
      return 2'd0;
   endfunction

   function automatic logic [W-1:0] make_inst(input logic [3:0] i_s, input logic [3:0] o_s, input logic [17:0] n);
      logic [W-1:0] v;
      v = {$urandom(), $urandom(), $urandom(), $urandom()};
      v[4:1]     = i_s;
      v[10:7]    = o_s;
      v[127:110] = n;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one instruction and holds it until accepted; inst_valid stays high on return.
   task automatic apply_stimulus(input logic [W-1:0] inst, input logic [TAG_W-1:0] tag, output int stalls);
      exp_t e;
      bus.inst_valid = 1'b1;
      bus.inst_data  = inst;
      bus.inst_tag   = tag;
      e.tag    = tag;
      e.status = model_status(inst);
      e.inst   = inst;
      sb.push_back(e);
      stalls = 0;
      while (!bus.inst_ready && stalls < 200) begin
         tick();
         stalls++;
      end
      check_output("accept", W'(bus.inst_ready), W'(1));
      tick();
   endtask

   task automatic wait_retired(input int target, input int budget, input string name);
      for (int i = 0; i < budget && retired < target; i++) begin
         tick();
      end
      check_output(name, W'(retired), W'(target));
   endtask

   // MM engine model: answers each ap_start with ap_done done_delay cycles later.
   always @(posedge clk) begin
      #2;
      eng_done = 1'b0;
      if (rst) begin
         done_timer = 0;
      end else begin
         if (done_timer > 0) begin
            done_timer--;
            if (done_timer == 0) eng_done = 1'b1;
         end
         if (bus.ap_start) begin
            starts++;
            done_timer = done_delay;
         end
      end
   end

   // Retire scoreboard and START+WAIT cycle model.
   always @(negedge clk) begin
      if (rst) begin
         in_exec = 1'b0;
      end else begin
         if (bus.ap_start) in_exec = 1'b1;
         if (in_exec) exec_cycles++;
         if (in_exec && bus.ap_done && !bus.ap_start) in_exec = 1'b0;
         if (bus.ret_valid && bus.ret_ready) begin
            if (sb.size() == 0) begin
               check_output("stale_retire", W'(bus.ret_tag), W'(0) - W'(1));
            end else begin
               exp_t e;
               e = sb.pop_front();
               check_output("ret_tag", W'(bus.ret_tag), W'(e.tag));
               check_output("ret_status", W'(bus.ret_status), W'(e.status));
               check_output("ret_ctrl", bus.ctrl_instruction, e.inst);
            end
            retired++;
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int           stalls;
      int           s0;
      int           r0;
      int           bad;
      logic [W-1:0] held;
      logic [W-1:0] inst1;
      logic [TAG_W-1:0] hold_tag;
      logic [1:0]   hold_status;

      rst            = 1'b1;
      bus.inst_valid = 1'b0;
      bus.inst_data  = '0;
      bus.inst_tag   = '0;
      bus.ret_ready  = 1'b1;

      // Reset values
      repeat (3) tick();
      @(negedge clk);
      check_output("rst_inst_ready_low", W'(bus.inst_ready), W'(0));
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_output("rst_inst_ready", W'(bus.inst_ready), W'(1));
      check_output("rst_ctrl", bus.ctrl_instruction, '0);
      check_output("rst_ap_start", W'(bus.ap_start), W'(0));
      check_output("rst_ret_valid", W'(bus.ret_valid), W'(0));
      check_output("rst_ret_tag", W'(bus.ret_tag), W'(0));
      check_output("rst_ret_status", W'(bus.ret_status), W'(0));
      check_output("rst_busy", W'(busy), W'(0));
      check_output("rst_perf", W'(perf), W'(0));
      tick();

      // 1: single legal instruction, ap_done 20 cycles after ap_start
      $display("[TB] test 1: single legal instruction");
      done_delay = 20;
      s0 = starts;
      inst1 = make_inst(BUF_1A, BUF_2A, 18'd16);
      apply_stimulus(inst1, 8'd5, stalls);
      bus.inst_valid = 1'b0;
      @(negedge clk);
      check_output("t1_no_start_at_pop", W'(bus.ap_start), W'(0));
      check_output("t1_busy", W'(busy), W'(1));
      @(negedge clk);
      check_output("t1_start_latency", W'(bus.ap_start), W'(1));
      check_output("t1_ctrl", bus.ctrl_instruction, inst1);
      held = bus.ctrl_instruction;
      bad = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (bus.ctrl_instruction !== held) bad++;
      end
      check_output("t1_ctrl_stable", W'(bad), W'(0));
      #1;
      wait_retired(1, 20, "t1_retired");
      check_output("t1_one_start", W'(starts - s0), W'(1));

      // 2: N==0 skips the engine
      $display("[TB] test 2: skip");
      s0 = starts;
      apply_stimulus(make_inst(BUF_1B, BUF_2B, 18'd0), 8'd7, stalls);
      bus.inst_valid = 1'b0;
      wait_retired(2, 3, "t2_retired_fast");
      check_output("t2_no_start", W'(starts - s0), W'(0));

      // 3: illegal buffer selects
      $display("[TB] test 3: illegal fields");
      s0 = starts;
      apply_stimulus(make_inst(BUF_2A, BUF_2A, 18'd9), 8'd9, stalls);
      apply_stimulus(make_inst(4'b0011, BUF_2A, 18'd5), 8'd10, stalls);
      apply_stimulus(make_inst(BUF_1A, BUF_1B, 18'd3), 8'd11, stalls);
      bus.inst_valid = 1'b0;
      wait_retired(5, 20, "t3_retired");
      check_output("t3_no_start", W'(starts - s0), W'(0));

      // 4: six back-to-back instructions against a 4-deep queue
      $display("[TB] test 4: back-to-back with backpressure");
      done_delay = 8;
      s0 = starts;
      for (int i = 0; i < 6; i++) begin
         logic [3:0] i_s;
         logic [3:0] o_s;
         i_s = (i % 2 == 0) ? BUF_1A : BUF_1B;
         o_s = (i % 3 == 0) ? BUF_2A : BUF_2B;
         apply_stimulus(make_inst(i_s, o_s, 18'(i + 1)), 8'(i), stalls);
         if (i == 4) check_output("t4_ready_drop", W'(bus.inst_ready), W'(0));
         if (i == 5) check_output("t4_stalled", W'(stalls > 0), W'(1));
      end
      bus.inst_valid = 1'b0;
      wait_retired(11, 200, "t4_retired");
      check_output("t4_starts", W'(starts - s0), W'(6));
      check_output("t4_sb_empty", W'(sb.size()), W'(0));

      // 5: retire backpressure and spurious ap_done
      $display("[TB] test 5: retire hold");
      done_delay = 3;
      bus.ret_ready = 1'b0;
      apply_stimulus(make_inst(BUF_1A, BUF_2B, 18'd40), 8'd20, stalls);
      apply_stimulus(make_inst(BUF_1B, BUF_2A, 18'd41), 8'd21, stalls);
      bus.inst_valid = 1'b0;
      for (int i = 0; i < 20 && !bus.ret_valid; i++) tick();
      check_output("t5_ret_valid", W'(bus.ret_valid), W'(1));
      check_output("t5_ret_tag", W'(bus.ret_tag), W'(20));
      check_output("t5_ret_status", W'(bus.ret_status), W'(0));
      hold_tag    = bus.ret_tag;
      hold_status = bus.ret_status;
      held        = bus.ctrl_instruction;
      s0  = starts;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         spur_done = (i == 3);
         tick();
         if (!bus.ret_valid || bus.ret_tag !== hold_tag || bus.ret_status !== hold_status
             || bus.ctrl_instruction !== held) bad++;
      end
      spur_done = 1'b0;
      check_output("t5_hold_stable", W'(bad), W'(0));
      check_output("t5_no_start", W'(starts - s0), W'(0));
      bus.ret_ready = 1'b1;
      wait_retired(13, 30, "t5_retired");
      repeat (2) tick();
      r0 = retired;
      s0 = starts;
      spur_done = 1'b1;
      tick();
      spur_done = 1'b0;
      repeat (4) tick();
      check_output("t5_idle_done_ret", W'(retired - r0), W'(0));
      check_output("t5_idle_done_start", W'(starts - s0), W'(0));
      check_output("t5_idle_busy", W'(busy), W'(0));
`ifdef MM_DISPATCH_PERF_EN
      check_output("perf_cycles", W'(perf), W'(exec_cycles));
`else
      check_output("perf_tied_zero", W'(perf), W'(0));
`endif
      $display("[TB] engine busy cycles modelled: %0d", exec_cycles);

      // 6: reset during WAIT with three entries queued
      $display("[TB] test 6: reset mid-operation");
      done_delay = 50;
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(make_inst(BUF_1A, BUF_2B, 18'(100 + i)), 8'(30 + i), stalls);
      end
      bus.inst_valid = 1'b0;
      repeat (3) tick();
      check_output("t6_busy_before", W'(busy), W'(1));
      r0  = retired;
      rst = 1'b1;
      @(negedge clk);
      check_output("t6_ready_in_rst", W'(bus.inst_ready), W'(0));
      tick();
      rst = 1'b0;
      sb.delete();
      @(negedge clk);
      check_output("t6_inst_ready", W'(bus.inst_ready), W'(1));
      check_output("t6_ctrl", bus.ctrl_instruction, '0);
      check_output("t6_ap_start", W'(bus.ap_start), W'(0));
      check_output("t6_ret_valid", W'(bus.ret_valid), W'(0));
      check_output("t6_ret_tag", W'(bus.ret_tag), W'(0));
      check_output("t6_ret_status", W'(bus.ret_status), W'(0));
      check_output("t6_busy", W'(busy), W'(0));
      check_output("t6_perf", W'(perf), W'(0));
      #1;
      s0 = starts;
      repeat (60) tick();
      check_output("t6_no_start", W'(starts - s0), W'(0));
      check_output("t6_no_retire", W'(retired - r0), W'(0));
      check_output("t6_idle", W'(busy), W'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
